seq_control_unit: RTL and testbench

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

---
 rtl/seq_ctrl_pkg.sv | 39 +++
 rtl/seq_ctrl_decode.sv | 30 +++
 rtl/seq_control_unit.sv | 133 +++++++++++++
 tb/tb_seq_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the sequential control unit.
// Optional memory-op support is enabled by defining CTRL_LDST_EN.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_CALC,
    S_STORE
`ifdef CTRL_LDST_EN
    , S_MEM
`endif
  } state_t;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_MEM = 2'b10;
  localparam logic [1:0] FMT_BAD = 2'b11;

  localparam int FMT_LSB = 0;
  localparam int ALU_LSB = 2;
  localparam int IMM_LSB = 5;
  localparam int RS_LSB  = 10;
  localparam int RD_LSB  = 13;

  localparam logic [3:0] MUX_IMM = 4'b1000;
  localparam logic [3:0] MUX_MEM = 4'b1001;

  typedef struct packed {
    logic [1:0] fmt;
    logic [2:0] alu;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm8;
  } fields_t;

endpackage

// File: rtl/seq_ctrl_decode.sv
// Field extraction and legality check for one 16-bit instruction word.
// Memory-format words are legal only when CTRL_LDST_EN is defined.
import seq_ctrl_pkg::*;

module seq_ctrl_decode #(
  parameter int NUM_REGS = 8
) (
  input  logic [15:0] instr,
  output fields_t     fields,
  output logic        legal
);

  always_comb begin
    fields.fmt  = instr[FMT_LSB +: 2];
    fields.alu  = instr[ALU_LSB +: 3];
    fields.rd   = instr[RD_LSB +: 3];
    fields.rs   = instr[RS_LSB +: 3];
    fields.imm8 = instr[IMM_LSB +: 8];

    legal = 1'b1;
    if (fields.fmt == FMT_BAD) legal = 1'b0;
`ifndef CTRL_LDST_EN
    if (fields.fmt == FMT_MEM) legal = 1'b0;
`endif
    if (int'(fields.rd) >= NUM_REGS) legal = 1'b0;
    // rs overlaps the immediate in I-type words, so it is only range-checked for R-type
    if ((fields.fmt == FMT_R) && (int'(fields.rs) >= NUM_REGS)) legal = 1'b0;
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit: fetch, decode, load, calc, store for a small register datapath.
// Define CTRL_LDST_EN to add the MEM state and the mem_req/mem_we/mem_ack handshake.
import seq_ctrl_pkg::*;

module seq_control_unit #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [15:0]         d_in,
  output logic                en_i,
  output logic                en_s,
  output logic                en_c,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [2:0]          alu_sel,
  output logic [3:0]          mux_sel,
  output logic [DATA_W-1:0]   imm_val,
  output logic                done,
  output logic                illegal,
  output logic                busy
`ifdef CTRL_LDST_EN
  ,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ack
`endif
);

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] dec_word;
  fields_t     f;
  logic        legal;
  logic        is_mem;

  // The legality verdict is needed during DECODE itself, before instr_q holds the word
  assign dec_word = (state_q == S_DECODE) ? d_in : instr_q;

  seq_ctrl_decode #(.NUM_REGS(NUM_REGS)) u_decode (
    .instr  (dec_word),
    .fields (f),
    .legal  (legal)
  );

`ifdef CTRL_LDST_EN
  assign is_mem = (f.fmt == FMT_MEM);
`else
  assign is_mem = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) instr_q <= d_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = S_CALC;
      S_CALC:   state_d = S_STORE;
`ifdef CTRL_LDST_EN
      S_MEM:    if (mem_ack) state_d = S_STORE;
`endif
      S_STORE:  state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef CTRL_LDST_EN
    if ((state_q == S_CALC) && is_mem) state_d = S_MEM;
`endif
  end

  always_comb begin
    en_i    = 1'b0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    reg_en  = '0;
    alu_sel = '0;
    mux_sel = '0;
    imm_val = '0;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (state_q != S_IDLE);
`ifdef CTRL_LDST_EN
    mem_req = 1'b0;
    mem_we  = 1'b0;
`endif
    case (state_q)
      S_FETCH: en_i = 1'b1;
      S_DECODE: begin
        illegal = !legal;
        done    = !legal;
      end
      S_LOAD: begin
        en_s    = 1'b1;
        mux_sel = {1'b0, f.rd};
      end
      S_CALC: begin
        en_c    = 1'b1;
        alu_sel = f.alu;
        if (f.fmt == FMT_R) mux_sel = {1'b0, f.rs};
        if (f.fmt == FMT_I) begin
          mux_sel = MUX_IMM;
          imm_val = DATA_W'(signed'(f.imm8));
        end
      end
`ifdef CTRL_LDST_EN
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = f.alu[0];
        mux_sel = {1'b0, f.rs};
      end
`endif
      S_STORE: begin
        done = 1'b1;
        // A memory store only signals completion; everything else writes rd
        if (!(is_mem && f.alu[0])) reg_en = NUM_REGS'(1) << f.rd;
        if (is_mem && !f.alu[0]) mux_sel = MUX_MEM;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench: an 8-register and a 4-register instance run against a phase-based model.
module tb_seq_control_unit;

  typedef struct packed {
    logic        en_i;
    logic        en_s;
    logic        en_c;
    logic [7:0]  reg_en;
    logic [2:0]  alu_sel;
    logic [3:0]  mux_sel;
    logic [15:0] imm_val;
    logic        done;
    logic        illegal;
    logic        busy;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] d_in = '0;

  logic        en_iA, en_sA, en_cA, doneA, illegalA, busyA;
  logic [7:0]  reg_enA;
  logic [2:0]  alu_selA;
  logic [3:0]  mux_selA;
  logic [15:0] imm_valA;

  logic        en_iB, en_sB, en_cB, doneB, illegalB, busyB;
  logic [3:0]  reg_enB;
  logic [2:0]  alu_selB;
  logic [3:0]  mux_selB;
  logic [15:0] imm_valB;

  int checkCount = 0;
  int passCount  = 0;

  int          ph [2] = '{0, 0};
  logic [15:0] ins [2] = '{16'h0, 16'h0};
  outs_t       eA, eB;

  always #5 clk = ~clk;

  seq_control_unit #(.NUM_REGS(8), .DATA_W(16)) dutA (
    .clk(clk), .reset(reset), .run(run), .d_in(d_in),
    .en_i(en_iA), .en_s(en_sA), .en_c(en_cA), .reg_en(reg_enA),
    .alu_sel(alu_selA), .mux_sel(mux_selA), .imm_val(imm_valA),
    .done(doneA), .illegal(illegalA), .busy(busyA)
  );

  seq_control_unit #(.NUM_REGS(4), .DATA_W(16)) dutB (
    .clk(clk), .reset(reset), .run(run), .d_in(d_in),
    .en_i(en_iB), .en_s(en_sB), .en_c(en_cB), .reg_en(reg_enB),
    .alu_sel(alu_selB), .mux_sel(mux_selB), .imm_val(imm_valB),
    .done(doneB), .illegal(illegalB), .busy(busyB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] w);
    run  = r;
    d_in = w;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int nregsOf(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic bit isLegal(input logic [15:0] w, input int nregs);
    int fmt, rd, rs;
    fmt = int'(w[1:0]);
    rd  = int'(w[15:13]);
    rs  = int'(w[12:10]);
    if (fmt >= 2) return 1'b0;
    if (rd >= nregs) return 1'b0;
    if (fmt == 0 && rs >= nregs) return 1'b0;
    return 1'b1;
  endfunction

  // Phase 0 idle, 1 fetch, 2 decode, 3 load, 4 calc, 5 store
  function automatic outs_t expectOut(input int p, input logic [15:0] w, input logic [15:0] din, input int nregs);
    outs_t o;
    int imm;
    o = '0;
    o.busy = (p != 0);
    case (p)
      1: o.en_i = 1'b1;
      2: if (!isLegal(din, nregs)) begin
           o.illegal = 1'b1;
           o.done    = 1'b1;
         end
      3: begin
           o.en_s    = 1'b1;
           o.mux_sel = 4'(w[15:13]);
         end
      4: begin
           o.en_c    = 1'b1;
           o.alu_sel = w[4:2];
           if (w[1:0] == 2'b00) o.mux_sel = 4'(w[12:10]);
           else begin
             o.mux_sel = 4'd8;
             imm = int'(w[12:5]);
             if (imm >= 128) imm = imm - 256;
             o.imm_val = 16'(imm);
           end
         end
      5: begin
           o.reg_en = 8'(1 << int'(w[15:13]));
           o.done   = 1'b1;
         end
      default: ;
    endcase
    return o;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        ph[k]  = 0;
        ins[k] = '0;
      end else begin
        case (ph[k])
          0: ph[k] = run ? 1 : 0;
          2: begin
               ins[k] = d_in;
               ph[k]  = isLegal(d_in, nregsOf(k)) ? 3 : 0;
             end
          5: ph[k] = run ? 1 : 0;
          default: ph[k] = ph[k] + 1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    eA = expectOut(ph[0], ins[0], d_in, 8);
    eB = expectOut(ph[1], ins[1], d_in, 4);
    checkOutput("A.en_i",    32'(en_iA),    32'(eA.en_i));
    checkOutput("A.en_s",    32'(en_sA),    32'(eA.en_s));
    checkOutput("A.en_c",    32'(en_cA),    32'(eA.en_c));
    checkOutput("A.reg_en",  32'(reg_enA),  32'(eA.reg_en));
    checkOutput("A.alu_sel", 32'(alu_selA), 32'(eA.alu_sel));
    checkOutput("A.mux_sel", 32'(mux_selA), 32'(eA.mux_sel));
    checkOutput("A.imm_val", 32'(imm_valA), 32'(eA.imm_val));
    checkOutput("A.done",    32'(doneA),    32'(eA.done));
    checkOutput("A.illegal", 32'(illegalA), 32'(eA.illegal));
    checkOutput("A.busy",    32'(busyA),    32'(eA.busy));
    checkOutput("B.en_i",    32'(en_iB),    32'(eB.en_i));
    checkOutput("B.en_s",    32'(en_sB),    32'(eB.en_s));
    checkOutput("B.en_c",    32'(en_cB),    32'(eB.en_c));
    checkOutput("B.reg_en",  32'(reg_enB),  32'(eB.reg_en));
    checkOutput("B.alu_sel", 32'(alu_selB), 32'(eB.alu_sel));
    checkOutput("B.mux_sel", 32'(mux_selB), 32'(eB.mux_sel));
    checkOutput("B.imm_val", 32'(imm_valB), 32'(eB.imm_val));
    checkOutput("B.done",    32'(doneB),    32'(eB.done));
    checkOutput("B.illegal", 32'(illegalB), 32'(eB.illegal));
    checkOutput("B.busy",    32'(busyB),    32'(eB.busy));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCnt, lastDone, firstDone, idleSeen;

    applyStimulus(1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("rst.busy",   32'(busyA),   32'd0);
    checkOutput("rst.reg_en", 32'(reg_enA), 32'd0);
    nextCycle();
    reset = 1'b1;
    repeat (2) nextCycle();

    // R-type: rd=1 rs=3 alu=2
    applyStimulus(1'b1, 16'h2C08);
    nextCycle();
    applyStimulus(1'b0, 16'h2C08);
    @(negedge clk);
    checkOutput("R.fetch.en_i", 32'(en_iA), 32'd1);
    nextCycle(); @(negedge clk);
    checkOutput("R.decode.busy",    32'(busyA),    32'd1);
    checkOutput("R.decode.illegal", 32'(illegalA), 32'd0);
    nextCycle(); @(negedge clk);
    checkOutput("R.load.en_s",    32'(en_sA),    32'd1);
    checkOutput("R.load.mux_sel", 32'(mux_selA), 32'd1);
    nextCycle(); @(negedge clk);
    checkOutput("R.calc.en_c",    32'(en_cA),    32'd1);
    checkOutput("R.calc.mux_sel", 32'(mux_selA), 32'd3);
    checkOutput("R.calc.alu_sel", 32'(alu_selA), 32'd2);
    nextCycle(); @(negedge clk);
    checkOutput("R.store.reg_en",  32'(reg_enA), 32'h02);
    checkOutput("R.store.done",    32'(doneA),   32'd1);
    checkOutput("R.store.reg_enB", 32'(reg_enB), 32'h2);
    nextCycle(); @(negedge clk);
    checkOutput("R.after.busy", 32'(busyA), 32'd0);

    // I-type: rd=2 imm8=FE alu=1
    applyStimulus(1'b1, 16'h5FC5);
    nextCycle();
    applyStimulus(1'b0, 16'h5FC5);
    nextCycle(); nextCycle(); @(negedge clk);
    checkOutput("I.load.imm_val", 32'(imm_valA), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("I.calc.imm_val", 32'(imm_valA), 32'hFFFE);
    checkOutput("I.calc.mux_sel", 32'(mux_selA), 32'h8);
    checkOutput("I.calc.alu_sel", 32'(alu_selA), 32'd1);
    nextCycle(); @(negedge clk);
    checkOutput("I.store.imm_val", 32'(imm_valA), 32'h0);
    checkOutput("I.store.reg_en",  32'(reg_enA),  32'h04);
    nextCycle();

    // Illegal: fmt=11
    applyStimulus(1'b1, 16'h0003);
    nextCycle();
    applyStimulus(1'b0, 16'h0003);
    nextCycle(); @(negedge clk);
    checkOutput("ill.fmt.illegal", 32'(illegalA), 32'd1);
    checkOutput("ill.fmt.done",    32'(doneA),    32'd1);
    checkOutput("ill.fmt.reg_en",  32'(reg_enA),  32'd0);
    nextCycle(); @(negedge clk);
    checkOutput("ill.fmt.idle", 32'(busyA), 32'd0);

    // rd=5: legal with 8 registers, illegal with 4
    applyStimulus(1'b1, 16'hA000);
    nextCycle();
    applyStimulus(1'b0, 16'hA000);
    nextCycle(); @(negedge clk);
    checkOutput("ill.rd.illegalB", 32'(illegalB), 32'd1);
    checkOutput("ill.rd.doneB",    32'(doneB),    32'd1);
    checkOutput("ill.rd.illegalA", 32'(illegalA), 32'd0);
    nextCycle(); @(negedge clk);
    checkOutput("ill.rd.idleB", 32'(busyB), 32'd0);
    checkOutput("ill.rd.loadA", 32'(en_sA), 32'd1);
    repeat (3) nextCycle();

    // rs=6 R-type (illegal only for 4 registers) and fmt=10 (illegal for both)
    applyStimulus(1'b1, 16'h1800);
    nextCycle();
    applyStimulus(1'b0, 16'h1800);
    repeat (6) nextCycle();
    applyStimulus(1'b1, 16'h0002);
    nextCycle();
    applyStimulus(1'b0, 16'h0002);
    nextCycle(); @(negedge clk);
    checkOutput("ill.mem.illegal", 32'(illegalA), 32'd1);
    repeat (2) nextCycle();

    // Reset asserted during CALC
    applyStimulus(1'b1, 16'h2C08);
    nextCycle();
    applyStimulus(1'b0, 16'h2C08);
    repeat (3) nextCycle();
    #2 reset = 1'b0;
    #1;
    checkOutput("rst.calc.en_c",    32'(en_cA),    32'd0);
    checkOutput("rst.calc.mux_sel", 32'(mux_selA), 32'd0);
    checkOutput("rst.calc.alu_sel", 32'(alu_selA), 32'd0);
    checkOutput("rst.calc.busy",    32'(busyA),    32'd0);
    nextCycle();
    reset = 1'b1;
    nextCycle(); @(negedge clk);
    checkOutput("rst.after.busy", 32'(busyA), 32'd0);
    nextCycle();

    // Back-to-back: three instructions with run held high
    applyStimulus(1'b1, 16'h6408);
    nextCycle();
    doneCnt = 0; lastDone = -1; firstDone = -1; idleSeen = 0;
    for (int c = 0; c < 17; c++) begin
      if (c == 14) run = 1'b0;
      @(negedge clk);
      if (c <= 14 && !busyA) idleSeen++;
      if (doneA) begin
        if (doneCnt == 0) firstDone = c;
        else checkOutput("b2b.spacing", 32'(c - lastDone), 32'd5);
        lastDone = c;
        doneCnt++;
      end
      nextCycle();
    end
    checkOutput("b2b.first", 32'(firstDone), 32'd4);
    checkOutput("b2b.count", 32'(doneCnt),   32'd3);
    checkOutput("b2b.gaps",  32'(idleSeen),  32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
